gc_stream_receiver: RTL
=======================

Name: gc_stream_receiver

Overview:
- Evaluator-side sink for the garbler's tagged output stream (tag/index0/index1/data0/data1).
- Decodes each beat and stores:
  - the session keys,
  - the input labels (with per-entry valid flags),
  - the garbled-table row pairs, written sequentially,
  - the output-mask word.
- Exposes synchronous read ports so the evaluation engine can fetch labels and table rows as they arrive.

Parameters:
- S, 20, index width of the stream (matches the garbler).
- K, 128, label/data width.
- LBL_AW, 10, label memory address width (2**LBL_AW entries).
- GT_AW, 11, garbled-table memory address width (2**GT_AW rows, two rows per gate).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- clear  in  1  synchronous session clear.
- tag  in  3  stream tag: 000 none, 001 keys, 010 table pair, 011 masks, 1ab input labels.
- index0  in  S  index for data0.
- index1  in  S  index for data1.
- data0  in  K  payload word 0.
- data1  in  K  payload word 1.
- lbl_rd_addr  in  LBL_AW  label read address.
- lbl_rd_data  out  K  label read data.
- lbl_rd_hit  out  1  label entry written.
- gt_rd_index  in  S  gate-table index (rows 2i, 2i+1).
- gt_rd_data0  out  K  row 2i.
- gt_rd_data1  out  K  row 2i+1.
- gt_rd_valid  out  1  index < gt_count at sample time.
- gt_count  out  S  number of table pairs received.
- key_r  out  K  latched data0 of the keys beat.
- key_aes  out  K  latched data1 of the keys beat.
- key_valid  out  1  keys latched.
- mask_out  out  2K  {data1,data0} of the masks beat.
- mask_valid  out  1  masks latched.
- busy  out  1  state == STREAM.
- err  out  4  sticky {err_range, err_dup, err_seq, err_tag}.

Behaviour:
- Reset (rst low, asynchronous) drives the following to 0:
  - all outputs,
  - the label flag vector,
  - gt_count,
  - state = IDLE.
- Memories hold no reset value; they are guarded by the flag vector and by gt_count.
- States: IDLE, STREAM, DONE. The tag is decoded every cycle.
- IDLE:
  - Tag 001: latch key_r = data0, key_aes = data1, set key_valid, go to STREAM.
  - Any other non-zero tag: set err_tag; the beat is dropped.
- STREAM, tag 1ab:
  - tag[0] writes data0 at index0.
  - tag[1] writes data1 at index1.
  - Both writes occur in the same cycle; each sets its flag.
  - index >= 2**LBL_AW: set err_range and drop that half of the beat.
  - Target flag already set: set err_dup and keep the original data.
  - index0 == index1 with both enables set: the data0 write wins and err_dup is set.
- STREAM, tag 010:
  - Required: index0 == 2*gt_count and index1 == index0+1.
  - If required condition holds: write the pair at row gt_count, then gt_count += 1.
  - If it does not hold: set err_seq; no write, no increment.
  - gt_count == 2**GT_AW: set err_range, no write.
- STREAM, tag 011: latch mask_out = {data1,data0}, set mask_valid, go to DONE.
- STREAM, tag 001: set err_tag and ignore the beat.
- DONE: all tags are ignored and produce no error. Read ports remain live.
- clear = 1 (any state), on the next edge:
  - state = IDLE,
  - flags, gt_count, key_valid, mask_valid and err all cleared,
  - clear has priority over a same-cycle stream beat.
- Label read:
  - 1-cycle latency; lbl_rd_data and lbl_rd_hit are registered from lbl_rd_addr.
  - Same-cycle write to the same address bypasses, returning the new data with hit = 1.
- Table read:
  - 1-cycle latency.
  - gt_rd_valid is registered from (gt_rd_index < gt_count).
  - A pair written in cycle t is readable with valid when gt_rd_index is presented in cycle t+1 (data appears at t+2).
  - Invalid reads return don't-care data.
- Arithmetic: all index compares are unsigned on S bits; gt_count does not wrap (saturates, guarded by err_range).

Optional Feature:
- Macro: GC_RX_STATS_EN.
- Defined:
  - Adds output lbl_count (S bits): number of label writes that were accepted.
  - Adds output stall_cycles (32 bits): counts STREAM cycles with tag 000, saturating at all-ones.
  - Both are cleared by rst and by clear.
- Undefined: neither port nor the counter logic exists.

Test Plan:
- Keys: rst low then high; tag=001, data0=0xA5.., data1=0x3C.. -> next cycle key_valid=1, key_r=0xA5.., busy=1.
- Labels: in STREAM, tag=111, index0=2, index1=3, data0=X, data1=Y.
  - Reading addr 3 -> lbl_rd_hit=1, data=Y.
  - Addr 4 -> hit=0.
  - Repeat tag=101, index0=2, data0=Z -> err[2]=1 and addr 2 still reads X.
- Tables: tag=010 with index pairs (0,1), (2,3), then (6,7) -> gt_count=2, err[1]=1.
  - gt_rd_index=1 -> valid=1 with the second pair.
  - gt_rd_index=2 -> valid=0.
- Masks: tag=011, data0=1, data1=0 -> mask_out bit0=1, mask_valid=1, busy=0; a following tag=111 changes nothing.
- Protocol errors:
  - tag=010 while in IDLE -> err[0]=1, state stays IDLE.
  - tag=101 with index0=2**LBL_AW -> err[3]=1.
- Clear/reset: assert clear in the same cycle as tag=101 -> state IDLE, all flags 0, write dropped.
  - Pulse rst low mid-STREAM asynchronously -> outputs 0 immediately.

Source files
------------

// File: rtl/gc_stream_receiver.sv
// gc_stream_receiver
//   Evaluator-side sink for the garbler's tagged output stream. Each beat
//   carries a tag, two indices and two payload words. The beat is decoded
//   into one of these stores:
//     - session keys,
//     - input labels, each with its own valid flag,
//     - garbled-table row pairs, which must arrive in order,
//     - the output-mask word.
//   Synchronous read ports let the evaluation engine fetch labels and table
//   rows while the stream is still arriving.
//
// Ports
//   clk, rst (async active-low), clear (sync session clear)
//   tag/index0/index1/data0/data1          : incoming stream beat
//   lbl_rd_addr -> lbl_rd_data, lbl_rd_hit  : label read, 1-cycle latency
//   gt_rd_index -> gt_rd_data0/1, gt_rd_valid : table-pair read, 1-cycle latency
//   gt_count                               : table pairs accepted
//   key_r, key_aes, key_valid              : latched session keys
//   mask_out, mask_valid                   : latched output masks
//   busy                                   : receiver is in STREAM
//   err                                    : sticky {range, dup, seq, tag}
//
// Optional build macro GC_RX_STATS_EN adds the following outputs:
//   lbl_count    : accepted label writes
//   stall_cycles : STREAM cycles with an idle tag, saturating
module gc_stream_receiver #(
    parameter int S      = 20,
    parameter int K      = 128,
    parameter int LBL_AW = 10,
    parameter int GT_AW  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [2:0]        tag,
    input  logic [S-1:0]      index0,
    input  logic [S-1:0]      index1,
    input  logic [K-1:0]      data0,
    input  logic [K-1:0]      data1,
    input  logic [LBL_AW-1:0] lbl_rd_addr,
    output logic [K-1:0]      lbl_rd_data,
    output logic              lbl_rd_hit,
    input  logic [S-1:0]      gt_rd_index,
    output logic [K-1:0]      gt_rd_data0,
    output logic [K-1:0]      gt_rd_data1,
    output logic              gt_rd_valid,
    output logic [S-1:0]      gt_count,
    output logic [K-1:0]      key_r,
    output logic [K-1:0]      key_aes,
    output logic              key_valid,
    output logic [2*K-1:0]    mask_out,
    output logic              mask_valid,
    output logic              busy,
`ifdef GC_RX_STATS_EN
    output logic [S-1:0]      lbl_count,
    output logic [31:0]       stall_cycles,
`endif
    output logic [3:0]        err
);

    localparam int LBL_N = 2 ** LBL_AW;
    localparam int GT_N  = 2 ** GT_AW;
    localparam logic [S-1:0] GT_FULL = S'(GT_N);

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;
    state_t state;

    logic [K-1:0]       lbl_mem [LBL_N];
    logic [K-1:0]       gt_mem0 [GT_N];
    logic [K-1:0]       gt_mem1 [GT_N];
    logic [LBL_N-1:0]   lbl_flag;

    logic [LBL_AW-1:0]  a0, a1;
    logic               en0, en1, in0, in1, same;
    logic               we0, we1;
    logic               gt_beat, gt_full, gt_seq_ok, gt_we;
    logic               e_range, e_dup, e_seq, e_tag;

    // Beat decode. Every term is gated by !clear so that clear wins outright.
    always_comb begin
        a0   = index0[LBL_AW-1:0];
        a1   = index1[LBL_AW-1:0];
        in0  = (index0[S-1:LBL_AW] == '0);
        in1  = (index1[S-1:LBL_AW] == '0);
        same = (index0 == index1);
        en0  = (state == ST_STREAM) && tag[2] && tag[0] && !clear;
        en1  = (state == ST_STREAM) && tag[2] && tag[1] && !clear;
        we0  = en0 && in0 && !lbl_flag[a0];
        // data0 owns a shared index; the data1 half is treated as a duplicate
        we1  = en1 && in1 && !lbl_flag[a1] && !(en0 && same);

        gt_beat   = (state == ST_STREAM) && (tag == 3'b010) && !clear;
        gt_full   = (gt_count == GT_FULL);
        gt_seq_ok = (index0 == {gt_count[S-2:0], 1'b0}) &&
                    (index1 == index0 + S'(1));
        gt_we     = gt_beat && !gt_full && gt_seq_ok;

        e_range = (en0 && !in0) || (en1 && !in1) || (gt_beat && gt_full);
        e_dup   = (en0 && in0 && lbl_flag[a0]) ||
                  (en1 && in1 && (lbl_flag[a1] || (en0 && same)));
        e_seq   = gt_beat && !gt_full && !gt_seq_ok;
        e_tag   = !clear &&
                  (((state == ST_IDLE) && (tag != 3'b000) && (tag != 3'b001)) ||
                   ((state == ST_STREAM) && (tag == 3'b001)));
    end

    // Payload storage carries no reset; validity comes from lbl_flag / gt_count.
    always_ff @(posedge clk) begin
        if (we0) lbl_mem[a0] <= data0;
        if (we1) lbl_mem[a1] <= data1;
        if (gt_we) begin
            gt_mem0[gt_count[GT_AW-1:0]] <= data0;
            gt_mem1[gt_count[GT_AW-1:0]] <= data1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            lbl_flag     <= '0;
            lbl_rd_data  <= '0;
            lbl_rd_hit   <= 1'b0;
            gt_rd_data0  <= '0;
            gt_rd_data1  <= '0;
            gt_rd_valid  <= 1'b0;
            gt_count     <= '0;
            key_r        <= '0;
            key_aes      <= '0;
            key_valid    <= 1'b0;
            mask_out     <= '0;
            mask_valid   <= 1'b0;
            err          <= '0;
`ifdef GC_RX_STATS_EN
            lbl_count    <= '0;
            stall_cycles <= '0;
`endif
        end else begin
            // Read ports stay live in every state, including during clear.
            if (we0 && (lbl_rd_addr == a0)) begin
                lbl_rd_data <= data0;
                lbl_rd_hit  <= 1'b1;
            end else if (we1 && (lbl_rd_addr == a1)) begin
                lbl_rd_data <= data1;
                lbl_rd_hit  <= 1'b1;
            end else begin
                lbl_rd_data <= lbl_mem[lbl_rd_addr];
                lbl_rd_hit  <= lbl_flag[lbl_rd_addr];
            end
            gt_rd_data0 <= gt_mem0[gt_rd_index[GT_AW-1:0]];
            gt_rd_data1 <= gt_mem1[gt_rd_index[GT_AW-1:0]];
            gt_rd_valid <= (gt_rd_index < gt_count);

            if (clear) begin
                state        <= ST_IDLE;
                lbl_flag     <= '0;
                gt_count     <= '0;
                key_valid    <= 1'b0;
                mask_valid   <= 1'b0;
                err          <= '0;
`ifdef GC_RX_STATS_EN
                lbl_count    <= '0;
                stall_cycles <= '0;
`endif
            end else begin
                err <= err | {e_range, e_dup, e_seq, e_tag};
                if (we0) lbl_flag[a0] <= 1'b1;
                if (we1) lbl_flag[a1] <= 1'b1;
                if (gt_we) gt_count <= gt_count + S'(1);
`ifdef GC_RX_STATS_EN
                lbl_count <= lbl_count + S'(we0) + S'(we1);
                if ((state == ST_STREAM) && (tag == 3'b000) && (stall_cycles != '1))
                    stall_cycles <= stall_cycles + 32'd1;
`endif
                case (state)
                    ST_IDLE: begin
                        if (tag == 3'b001) begin
                            key_r     <= data0;
                            key_aes   <= data1;
                            key_valid <= 1'b1;
                            state     <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (tag == 3'b011) begin
                            mask_out   <= {data1, data0};
                            mask_valid <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state == ST_STREAM);

endmodule
